// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared register-file widths, zero-register index and address type
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/pend_scoreboard.sv
// rtl/pend_scoreboard.sv - per-register pending bits with set-over-clear update
module pend_scoreboard import mips_pkg::*; #(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = 2**ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [ADDR_W-1:0]   set_addr,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_addr,
    output logic [NUM_REGS-1:0] pend,
    output logic                any_pending
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    // A new producer supersedes the retiring one, so set takes priority.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (set_en && int'(set_addr) == i) begin
                pend_d[i] = 1'b1;
            end else if (clr_en && int'(clr_addr) == i) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend        = pend_q;
    assign any_pending = |pend_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 2-read/1-write register file with write-through bypass and RAW scoreboard
module regfile_scoreboard import mips_pkg::*; #(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = 2**ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] Data1,
    output logic [DATA_W-1:0] Data2,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] writeData,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] reserveAddr,
    output logic              rsPending,
    output logic              rtPending,
    output logic              anyPending
);

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (int'(a) < NUM_REGS) && !(ZERO_REG != 0 && int'(a) == REG_ZERO);
    endfunction

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] pend;
    logic                wr_legal;
    logic                rsv_legal;

    // Reset gates the bypass as well as the state update.
    assign wr_legal  = regWrite && !rst && addr_ok(rd);
    assign rsv_legal = reserve && !rst && addr_ok(reserveAddr);

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_legal && int'(rd) == i) begin
                regs_d[i] = writeData;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    pend_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_pend (
        .clk         (clk),
        .rst         (rst),
        .set_en      (rsv_legal),
        .set_addr    (reserveAddr),
        .clr_en      (wr_legal),
        .clr_addr    (rd),
        .pend        (pend),
        .any_pending (anyPending)
    );

    // Out-of-range addresses fall through the loop and read as zero, never pending.
    always_comb begin
        Data1     = '0;
        Data2     = '0;
        rsPending = 1'b0;
        rtPending = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(rs) == i) begin
                Data1     = regs_q[i];
                rsPending = pend[i];
            end
            if (int'(rt) == i) begin
                Data2     = regs_q[i];
                rtPending = pend[i];
            end
        end
        if (wr_legal && rd == rs) begin
            Data1     = writeData;
            rsPending = 1'b0;
        end
        if (wr_legal && rd == rt) begin
            Data2     = writeData;
            rtPending = 1'b0;
        end
        if (ZERO_REG != 0 && int'(rs) == REG_ZERO) begin
            Data1 = '0;
        end
        if (ZERO_REG != 0 && int'(rt) == REG_ZERO) begin
            Data2 = '0;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed vector bench for regfile_scoreboard
module tb_regfile_scoreboard;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    reg_addr_t   rs, rt, rd, reserveAddr;
    logic [31:0] Data1, Data2, writeData;
    logic        regWrite, reserve;
    logic        rsPending, rtPending, anyPending;

    reg_addr_t   b_rs, b_rt, b_rd, b_reserveAddr;
    logic [15:0] b_Data1, b_Data2, b_writeData;
    logic        b_regWrite, b_reserve;
    logic        b_rsPending, b_rtPending, b_anyPending;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_scoreboard u_dut (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .Data1(Data1), .Data2(Data2),
        .regWrite(regWrite), .rd(rd), .writeData(writeData),
        .reserve(reserve), .reserveAddr(reserveAddr),
        .rsPending(rsPending), .rtPending(rtPending), .anyPending(anyPending)
    );

    regfile_scoreboard #(.DATA_W(16), .ADDR_W(5), .NUM_REGS(16), .ZERO_REG(1)) u_dut16 (
        .clk(clk), .rst(rst), .rs(b_rs), .rt(b_rt), .Data1(b_Data1), .Data2(b_Data2),
        .regWrite(b_regWrite), .rd(b_rd), .writeData(b_writeData),
        .reserve(b_reserve), .reserveAddr(b_reserveAddr),
        .rsPending(b_rsPending), .rtPending(b_rtPending), .anyPending(b_anyPending)
    );

    typedef struct {
        logic        we;
        reg_addr_t   wa;
        logic [31:0] wd;
        logic        rv;
        reg_addr_t   ra;
        reg_addr_t   s;
        reg_addr_t   t;
        logic [31:0] e_d1;
        logic [31:0] e_d2;
        logic        e_rsp;
        logic        e_rtp;
        logic        e_any;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        regWrite = 0; rd = 0; writeData = 0; reserve = 0; reserveAddr = 0;
        b_regWrite = 0; b_rd = 0; b_writeData = 0; b_reserve = 0; b_reserveAddr = 0;
    endtask

    initial begin
        rst = 1; rs = 0; rt = 0; b_rs = 0; b_rt = 0;
        idle();

        vecs[0]  = '{1, 1,  32'h11,       0, 0,  1,  2,  32'h11, 32'h0,  0, 0, 0};
        vecs[1]  = '{0, 0,  32'h0,        1, 2,  1,  2,  32'h11, 32'h0,  0, 0, 0};
        vecs[2]  = '{0, 0,  32'h0,        0, 0,  2,  1,  32'h0,  32'h11, 1, 0, 1};
        vecs[3]  = '{1, 2,  32'h22,       0, 0,  2,  2,  32'h22, 32'h22, 0, 0, 1};
        vecs[4]  = '{0, 0,  32'h0,        0, 0,  2,  0,  32'h22, 32'h0,  0, 0, 0};
        vecs[5]  = '{1, 0,  32'hFFFFFFFF, 1, 0,  0,  0,  32'h0,  32'h0,  0, 0, 0};
        vecs[6]  = '{0, 0,  32'h0,        0, 0,  0,  0,  32'h0,  32'h0,  0, 0, 0};
        vecs[7]  = '{1, 31, 32'hAB,       1, 31, 31, 1,  32'hAB, 32'h11, 0, 0, 0};
        vecs[8]  = '{0, 0,  32'h0,        0, 0,  31, 31, 32'hAB, 32'hAB, 1, 1, 1};
        vecs[9]  = '{1, 31, 32'hCD,       0, 0,  31, 1,  32'hCD, 32'h11, 0, 0, 1};
        vecs[10] = '{0, 0,  32'h0,        0, 0,  31, 2,  32'hCD, 32'h22, 0, 0, 0};

        @(negedge clk);
        rs = 5; rt = 7;
        #1;
        check("reset_d1", Data1, 32'h0);
        check("reset_any", {31'b0, anyPending}, 32'h0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 11; i++) begin
            regWrite = vecs[i].we; rd = vecs[i].wa; writeData = vecs[i].wd;
            reserve = vecs[i].rv; reserveAddr = vecs[i].ra;
            rs = vecs[i].s; rt = vecs[i].t;
            #1;
            check($sformatf("v%0d_d1", i), Data1, vecs[i].e_d1);
            check($sformatf("v%0d_d2", i), Data2, vecs[i].e_d2);
            check($sformatf("v%0d_rsp", i), {31'b0, rsPending}, {31'b0, vecs[i].e_rsp});
            check($sformatf("v%0d_rtp", i), {31'b0, rtPending}, {31'b0, vecs[i].e_rtp});
            check($sformatf("v%0d_any", i), {31'b0, anyPending}, {31'b0, vecs[i].e_any});
            @(negedge clk);
        end
        idle();

        // Scoreboard lifecycle on r3 with a writeback three cycles after reserve.
        reserve = 1; reserveAddr = 3; rs = 3;
        @(negedge clk);
        idle();
        #1;
        check("life_c2_rsp", {31'b0, rsPending}, 32'h1);
        @(negedge clk);
        #1;
        check("life_c3_rsp", {31'b0, rsPending}, 32'h1);
        @(negedge clk);
        regWrite = 1; rd = 3; writeData = 32'h55;
        #1;
        check("life_c4_rsp", {31'b0, rsPending}, 32'h0);
        check("life_c4_d1", Data1, 32'h55);
        @(negedge clk);
        idle();
        #1;
        check("life_c5_rsp", {31'b0, rsPending}, 32'h0);
        check("life_c5_any", {31'b0, anyPending}, 32'h0);

        // Set/clear collision on an already-pending r4.
        reserve = 1; reserveAddr = 4;
        @(negedge clk);
        regWrite = 1; rd = 4; writeData = 32'hA; rt = 4;
        #1;
        check("coll_same_rtp", {31'b0, rtPending}, 32'h0);
        @(negedge clk);
        idle();
        #1;
        check("coll_d2", Data2, 32'hA);
        check("coll_rtp", {31'b0, rtPending}, 32'h1);
        check("coll_any", {31'b0, anyPending}, 32'h1);
        regWrite = 1; rd = 4; writeData = 32'hA;
        @(negedge clk);
        idle();

        // Asynchronous reset mid-operation.
        regWrite = 1; rd = 5; writeData = 32'hDEADBEEF; reserve = 1; reserveAddr = 7;
        @(negedge clk);
        idle();
        rs = 5; rt = 7;
        #1;
        check("pre_rst_d1", Data1, 32'hDEADBEEF);
        check("pre_rst_rtp", {31'b0, rtPending}, 32'h1);
        #1;
        rst = 1;
        #1;
        check("rst_d1", Data1, 32'h0);
        check("rst_rtp", {31'b0, rtPending}, 32'h0);
        check("rst_any", {31'b0, anyPending}, 32'h0);
        regWrite = 1; rd = 5; writeData = 32'h77;
        #1;
        check("rst_no_bypass", Data1, 32'h0);
        @(negedge clk);
        idle();
        rst = 0;
        #1;
        check("post_rst_d1", Data1, 32'h0);

        // Narrow configuration: r20 is out of range, r15 is the last register.
        b_regWrite = 1; b_rd = 20; b_writeData = 16'h1234; b_reserve = 1; b_reserveAddr = 20;
        b_rs = 20;
        #1;
        check("p16_oor_bypass", {16'b0, b_Data1}, 32'h0);
        @(negedge clk);
        idle();
        #1;
        check("p16_oor_d1", {16'b0, b_Data1}, 32'h0);
        check("p16_oor_rsp", {31'b0, b_rsPending}, 32'h0);
        check("p16_oor_any", {31'b0, b_anyPending}, 32'h0);
        b_regWrite = 1; b_rd = 15; b_writeData = 16'hBEEF;
        @(negedge clk);
        idle();
        b_rs = 15; b_rt = 4;
        #1;
        check("p16_r15_d1", {16'b0, b_Data1}, 32'h0000BEEF);
        check("p16_r4_d2", {16'b0, b_Data2}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the pipeline's 2-read/1-write register file, used in the decode stage of the pipelined MIPS core.
- Adds the following over the current register file:
  - asynchronous reset that clears every register;
  - write-through bypass, so a writeback is visible to a same-cycle read;
  - a per-register pending scoreboard; the hazard unit uses its outputs to stall decode on RAW hazards against in-flight producers.
- Register 0 is optionally hardwired to zero.

Parameters:
- DATA_W, 32, register data width in bits
- ADDR_W, 5, register address width
- NUM_REGS, 2**ADDR_W, number of architectural registers (must be ≤ 2**ADDR_W)
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never pending

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- rs  input  ADDR_W  read address, port 1
- rt  input  ADDR_W  read address, port 2
- Data1  output  DATA_W  read data, port 1
- Data2  output  DATA_W  read data, port 2
- regWrite  input  1  writeback enable
- rd  input  ADDR_W  writeback address
- writeData  input  DATA_W  writeback data
- reserve  input  1  issue-stage request to mark a destination pending
- reserveAddr  input  ADDR_W  destination register being reserved
- rsPending  output  1  rs has an outstanding producer not resolved this cycle
- rtPending  output  1  rt has an outstanding producer not resolved this cycle
- anyPending  output  1  OR of all pending bits (pipeline drain indicator)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- State:
  - regs[NUM_REGS], each DATA_W bits;
  - pend[NUM_REGS], one bit each.
- Reset:
  - On rst assertion, all regs = 0 and all pend = 0 immediately, without waiting for a clock edge.
  - While rst is high, writes and reserves are ignored and bypass is disabled.
  - Consequence during reset: Data1 = Data2 = 0, rsPending = rtPending = anyPending = 0.
- Write:
  - At posedge clk, if regWrite and the write is legal, regs[rd] <= writeData.
  - A write is legal when rd < NUM_REGS and not (ZERO_REG and rd == 0).
- Read (combinational, 0-cycle latency):
  - Data1 = 0 if (ZERO_REG and rs == 0) or rs ≥ NUM_REGS.
  - Else Data1 = writeData if (regWrite and rd == rs and the write is legal).
  - Else Data1 = regs[rs].
  - Data2 is computed the same way using rt.
- Scoreboard update at posedge clk, per register index i:
  - set_i = reserve and reserveAddr == i and the reserve is legal (same legality rule as a write).
  - clr_i = regWrite and rd == i and the write is legal.
  - pend[i] <= set_i ? 1 : (clr_i ? 0 : pend[i]).
  - On simultaneous set and clear of the same register, set wins: a new producer supersedes the retiring one.
  - A reserve to an already-pending register keeps it pending. The design is single-outstanding per register, and the issue logic guarantees this.
  - A writeback to a non-pending register is legal: the data is written and pend is unchanged.
- Pending outputs (combinational):
  - rsPending = pend[rs] and not (regWrite and rd == rs and the write is legal). The same-cycle writeback resolves the hazard through the bypass.
  - rtPending is computed the same way using rt.
  - Same-cycle reserve does not affect rsPending/rtPending. It takes effect from the next cycle.
  - anyPending = |pend, registered state only.
- Out-of-range addresses (NUM_REGS < 2**ADDR_W):
  - Reads return 0 and are never pending.
  - Writes and reserves are dropped.

Decomposition:
- Shared package mips_pkg holds DATA_W and ADDR_W defaults, the REG_ZERO constant (0), and a reg_addr_t typedef.
- One natural sub-module, pend_scoreboard. It holds the pend vector with the set/clear/reset logic and the anyPending reduction. The data array and bypass muxes stay in the top module.

Test Plan:
- Reset mid-operation: write 0xDEADBEEF to r5, reserve r7, pulse rst between clock edges -> Data1(rs=5) = 0 immediately, rsPending(rs=7) = 0, anyPending = 0.
- Bypass: regWrite=1, rd=9, writeData=0x12345678, rs=9, rt=9 in the same cycle -> Data1 = Data2 = 0x12345678 before the edge; after the edge, regWrite=0 still reads 0x12345678.
- Zero register: regWrite=1, rd=0, writeData=0xFFFFFFFF; then reserve r0 -> Data1(rs=0) = 0 throughout, rsPending = 0, anyPending = 0.
- Scoreboard lifecycle: reserve r3 at cycle 1 -> rsPending(rs=3) = 1 from cycle 2. At cycle 4, regWrite rd=3 data 0x55 -> rsPending = 0 in cycle 4 with Data1 = 0x55, and pend[3] = 0 from cycle 5.
- Set/clear collision: r4 pending; same cycle reserve=1, reserveAddr=4, regWrite=1, rd=4, data 0xA -> regs[4] = 0xA, r4 still pending next cycle, rtPending(rt=4) = 1.
- Parametrisation: NUM_REGS=16, ADDR_W=5, DATA_W=16; write r20 = 0x1234, reserve r20 -> Data1(rs=20) = 0, rsPending = 0, anyPending = 0; r15 write/read of 0xBEEF works.
